elevator_call_scheduler: RTL

- Request-side initiator for the 4-floor elevator controller. It latches car and hall call buttons into a pending set and drives `floor_req` to the controller one target at a time, using SCAN (same-direction-first) ordering.
- It tracks the car position from the controller's `move_up`/`move_down` outputs. It retires a call when `door_open` rises at that floor.
- A watchdog drops targets the controller never services.

---
 rtl/elevator_call_scheduler.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// SCAN-ordered call scheduler for a 4-floor elevator controller: latches calls, issues one
// target at a time, tracks the car from the controller's move pulses and drops dead targets.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  move_up,
    input  logic                  move_down,
    input  logic                  door_open,
    output logic [1:0]            floor_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [1:0]            cur_floor,
    output logic                  dir_up,
    output logic                  busy,
    output logic                  serviced,
    output logic                  wdog_fault
);

    localparam int              WW        = $clog2(WDOG_CYCLES);
    localparam logic [WW-1:0]   WDOG_LAST = WW'(WDOG_CYCLES - 1);
    localparam logic [1:0]      TOP_FLOOR = 2'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] NO_FLOORS = {NUM_FLOORS{1'b0}};

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DISPATCH     = 2'd1,
        WAIT_SERVICE = 2'd2,
        HOLD         = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [NUM_FLOORS-1:0]   pending_r;
    logic [1:0]              cur_floor_r;
    logic [1:0]              floor_req_r;
    logic [1:0]              floor_req_s;
    logic                    dir_up_r;
    logic                    dir_up_s;
    logic                    busy_r;
    logic                    serviced_r;
    logic                    wdog_fault_r;
    logic [WW-1:0]           wdog_r;
    logic [WW-1:0]           wdog_s;
    logic                    door_q_r;

    logic [NUM_FLOORS-1:0]   cur_mask_s;
    logic [NUM_FLOORS-1:0]   set_mask_s;
    logic [NUM_FLOORS-1:0]   clr_mask_s;
    logic [NUM_FLOORS-1:0]   avail_s;
    logic                    door_rise_s;
    logic                    svc_s;
    logic                    tgt_svc_s;
    logic                    wdog_exp_s;
    logic [2:0]              above_s;
    logic [2:0]              below_s;
    logic [1:0]              pos_s;

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [1:0] f);
        floor_mask = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    // {found, floor}: nearest set bit strictly above f (loop runs top-down so the last hit wins)
    function automatic logic [2:0] nearest_above(input logic [NUM_FLOORS-1:0] p, input logic [1:0] f);
        logic [2:0] r;
        r = 3'b000;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            r = ((i > int'(f)) && p[i]) ? {1'b1, 2'(i)} : r;
        end
        return r;
    endfunction

    function automatic logic [2:0] nearest_below(input logic [NUM_FLOORS-1:0] p, input logic [1:0] f);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            r = ((i < int'(f)) && p[i]) ? {1'b1, 2'(i)} : r;
        end
        return r;
    endfunction

    // Call capture, service detection, watchdog expiry and position update
    always_comb begin
        cur_mask_s  = floor_mask(cur_floor_r);
        door_rise_s = door_open & ~door_q_r;
        svc_s       = door_rise_s & (|(pending_r & cur_mask_s));
        tgt_svc_s   = (state_r == WAIT_SERVICE) & svc_s & (cur_floor_r == floor_req_r);
        wdog_exp_s  = (state_r == WAIT_SERVICE) & ~tgt_svc_s & (wdog_r == WDOG_LAST);
        // presses at the floor whose door is open are already being served
        set_mask_s  = call_btn & ~(door_open ? cur_mask_s : NO_FLOORS);
        clr_mask_s  = (svc_s ? cur_mask_s : NO_FLOORS)
                    | (wdog_exp_s ? floor_mask(floor_req_r) : NO_FLOORS);
        avail_s     = pending_r & ~clr_mask_s;
        above_s     = nearest_above(avail_s, cur_floor_r);
        below_s     = nearest_below(avail_s, cur_floor_r);
        if (move_up && !move_down && (cur_floor_r != TOP_FLOOR)) begin
            pos_s = cur_floor_r + 2'd1;
        end else if (move_down && !move_up && (cur_floor_r != 2'd0)) begin
            pos_s = cur_floor_r - 2'd1;
        end else begin
            pos_s = cur_floor_r;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                state_s = (pending_r != NO_FLOORS) ? DISPATCH : IDLE;
            end
            DISPATCH: begin
                state_s = (avail_s != NO_FLOORS) ? WAIT_SERVICE : IDLE;
            end
            WAIT_SERVICE: begin
                if (tgt_svc_s) begin
                    state_s = HOLD;
                end else if (wdog_exp_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_SERVICE;
                end
            end
            HOLD: begin
                if (!door_open) begin
                    state_s = (pending_r != NO_FLOORS) ? DISPATCH : IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Target selection, sweep direction and watchdog count
    always_comb begin
        floor_req_s = floor_req_r;
        dir_up_s    = dir_up_r;
        wdog_s      = wdog_r;
        case (state_r)
            IDLE: begin
                floor_req_s = cur_floor_r;
            end
            DISPATCH: begin
                wdog_s = {WW{1'b0}};
                if (avail_s == NO_FLOORS) begin
                    floor_req_s = floor_req_r;
                end else if (|(avail_s & cur_mask_s)) begin
                    floor_req_s = cur_floor_r;
                end else if (dir_up_r) begin
                    if (above_s[2]) begin
                        floor_req_s = above_s[1:0];
                    end else begin
                        dir_up_s    = 1'b0;
                        floor_req_s = below_s[1:0];
                    end
                end else begin
                    if (below_s[2]) begin
                        floor_req_s = below_s[1:0];
                    end else begin
                        dir_up_s    = 1'b1;
                        floor_req_s = above_s[1:0];
                    end
                end
            end
            WAIT_SERVICE: begin
                if (wdog_exp_s) begin
                    wdog_s = wdog_r;
                end else begin
                    wdog_s = wdog_r + {{(WW-1){1'b0}}, 1'b1};
                end
            end
            HOLD: begin
                floor_req_s = floor_req_r;
            end
            default: begin
                floor_req_s = floor_req_r;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= NO_FLOORS;
            cur_floor_r  <= 2'd0;
            floor_req_r  <= 2'd0;
            dir_up_r     <= 1'b1;
            busy_r       <= 1'b0;
            serviced_r   <= 1'b0;
            wdog_fault_r <= 1'b0;
            wdog_r       <= {WW{1'b0}};
            door_q_r     <= 1'b0;
        end else begin
            pending_r    <= (pending_r | set_mask_s) & ~clr_mask_s;
            cur_floor_r  <= pos_s;
            floor_req_r  <= floor_req_s;
            dir_up_r     <= dir_up_s;
            busy_r       <= (state_s != IDLE);
            serviced_r   <= svc_s;
            wdog_fault_r <= wdog_fault_r | wdog_exp_s;
            wdog_r       <= wdog_s;
            door_q_r     <= door_open;
        end
    end

    assign floor_req  = floor_req_r;
    assign pending    = pending_r;
    assign cur_floor  = cur_floor_r;
    assign dir_up     = dir_up_r;
    assign busy       = busy_r;
    assign serviced   = serviced_r;
    assign wdog_fault = wdog_fault_r;

endmodule
